mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-ported memory between the instruction-fetch stage and the MEM-stage load/store unit of the five-stage MIPS pipeline. It grants the port with fixed data-over-fetch priority and drives the memory handshake. It returns read data with a one-cycle valid pulse to each requester. It produces `if_stall` and `dm_stall`, which the hazard logic ORs into the PC, IF/ID and pipeline stall/flush network.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store unit.
// Data has fixed priority over fetch; one access is outstanding at most.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_kill,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_done,
   output logic                dm_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready
);
   localparam int BE_W = DATA_W/8;

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

   state_t            state, state_nx;
   logic              kill, kill_nx;
   logic              dm_elig, if_elig, arb;
   logic              req_nx, we_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx;
   logic [BE_W-1:0]   be_nx;
   logic              if_valid_nx, dm_done_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         kill      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_valid  <= 1'b0;
         dm_done   <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         state     <= state_nx;
         kill      <= kill_nx;
         mem_req   <= req_nx;
         mem_we    <= we_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
         mem_be    <= be_nx;
         if_valid  <= if_valid_nx;
         dm_done   <= dm_done_nx;
         if (state == IF_BUSY && mem_ready)
            if_rdata <= mem_rdata;
         if (state == DM_BUSY && mem_ready)
            dm_rdata <= mem_rdata;
      end
   end

   // A requester whose access is completing or just completed still holds
   // its req for the old access, so it must not win a new grant.
   always_comb begin
      dm_elig  = dm_req & ~dm_done & (state != DM_BUSY);
      if_elig  = if_req & ~if_kill & ~if_valid & (state != IF_BUSY);
      arb      = (state == IDLE) | mem_ready;
      state_nx = state;
      req_nx   = mem_req;
      we_nx    = mem_we;
      addr_nx  = mem_addr;
      wdata_nx = mem_wdata;
      be_nx    = mem_be;
      if (arb) begin
         if (dm_elig) begin
            state_nx = DM_BUSY;
            req_nx   = 1'b1;
            we_nx    = dm_we;
            addr_nx  = dm_addr;
            wdata_nx = dm_wdata;
            be_nx    = dm_be;
         end else if (if_elig) begin
            state_nx = IF_BUSY;
            req_nx   = 1'b1;
            we_nx    = 1'b0;
            addr_nx  = if_addr;
            be_nx    = '1;
         end else begin
            state_nx = IDLE;
            req_nx   = 1'b0;
         end
      end
   end

   always_comb begin
      if_valid_nx = 1'b0;
      dm_done_nx  = 1'b0;
      kill_nx     = 1'b0;
      if (state == IF_BUSY) begin
         if (mem_ready)
            if_valid_nx = ~kill & ~if_kill;
         else
            kill_nx = kill | if_kill;
      end
      if (state == DM_BUSY)
         dm_done_nx = mem_ready;
      if_stall = if_req & ~if_valid;
      dm_stall = dm_req & ~dm_done;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, kill, load, reset.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_kill, if_valid, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_done, dm_stall;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
      .dm_done(dm_done), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      if_req = 0; if_kill = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
      mem_ready = 0; mem_rdata = 0;
      step; step;
      check("rst mem_req", mem_req, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst mem_be", mem_be, 0);
      check("rst if_valid", if_valid, 0);
      check("rst dm_done", dm_done, 0);
      check("rst if_rdata", if_rdata, 0);
      check("rst dm_rdata", dm_rdata, 0);
      rst_n = 1'b1;

      // fetch only
      if_req = 1; if_addr = 32'h100;
      #1 check("f stall c0", if_stall, 1);
      step;
      check("f mem_req", mem_req, 1);
      check("f mem_addr", mem_addr, 32'h100);
      check("f mem_be", mem_be, 4'hF);
      check("f mem_we", mem_we, 0);
      check("f stall c1", if_stall, 1);
      step;
      check("f stall c2", if_stall, 1);
      check("f valid c2", if_valid, 0);
      mem_ready = 1; mem_rdata = 32'h8C220004;
      step;
      mem_ready = 0;
      check("f valid", if_valid, 1);
      check("f rdata", if_rdata, 32'h8C220004);
      check("f stall c3", if_stall, 0);
      check("f no reissue", mem_req, 0);
      if_req = 0;
      step;
      check("f valid pulse", if_valid, 0);

      // simultaneous store and fetch
      if_req = 1; if_addr = 32'h104;
      dm_req = 1; dm_we = 1; dm_addr = 32'h2000;
      dm_wdata = 32'hDEADBEEF; dm_be = 4'h3;
      step;
      check("s mem_addr", mem_addr, 32'h2000);
      check("s mem_we", mem_we, 1);
      check("s mem_be", mem_be, 4'h3);
      check("s mem_wdata", mem_wdata, 32'hDEADBEEF);
      mem_ready = 1;
      step;
      check("s dm_done", dm_done, 1);
      check("s dm_stall", dm_stall, 0);
      check("s fetch req", mem_req, 1);
      check("s fetch addr", mem_addr, 32'h104);
      check("s fetch we", mem_we, 0);
      check("s fetch be", mem_be, 4'hF);
      check("s if_valid early", if_valid, 0);
      mem_rdata = 32'hAABBCCDD;
      step;
      dm_req = 0; mem_ready = 0;
      check("s if_valid", if_valid, 1);
      check("s if_rdata", if_rdata, 32'hAABBCCDD);
      check("s done once", dm_done, 0);
      if_req = 0;
      step;
      check("s idle", mem_req, 0);

      // kill in flight
      if_req = 1; if_addr = 32'h180;
      step;
      check("k mem_req", mem_req, 1);
      if_kill = 1; if_addr = 32'h200;
      step;
      if_kill = 0;
      check("k hold req", mem_req, 1);
      check("k hold addr", mem_addr, 32'h180);
      mem_ready = 1; mem_rdata = 32'h00000BAD;
      step;
      mem_ready = 0;
      check("k no valid", if_valid, 0);
      check("k idle", mem_req, 0);
      step;
      check("k new req", mem_req, 1);
      check("k new addr", mem_addr, 32'h200);
      check("k valid c4", if_valid, 0);
      mem_ready = 1; mem_rdata = 32'h0000ABCD;
      step;
      mem_ready = 0;
      check("k valid", if_valid, 1);
      check("k rdata", if_rdata, 32'h0000ABCD);
      if_req = 0;
      step;

      // kill on the ready cycle itself
      if_req = 1; if_addr = 32'h300;
      step;
      mem_ready = 1; if_kill = 1;
      step;
      mem_ready = 0; if_kill = 0;
      check("kr no valid", if_valid, 0);
      if_req = 0;
      step;

      // load
      dm_req = 1; dm_we = 0; dm_addr = 32'h3000; dm_be = 4'hF;
      step;
      check("l mem_addr", mem_addr, 32'h3000);
      check("l mem_we", mem_we, 0);
      mem_ready = 1; mem_rdata = 32'h12345678;
      step;
      mem_ready = 0;
      check("l dm_done", dm_done, 1);
      check("l dm_rdata", dm_rdata, 32'h12345678);
      check("l if_valid", if_valid, 0);
      check("l no reissue c2", mem_req, 0);
      step;
      dm_req = 0;
      check("l no reissue c3", mem_req, 0);
      check("l done pulse", dm_done, 0);

      // reset during DM_BUSY
      dm_req = 1; dm_we = 1; dm_addr = 32'h4000; dm_wdata = 32'h55;
      step;
      check("r busy", mem_req, 1);
      rst_n = 0; dm_req = 0;
      step;
      rst_n = 1;
      check("r mem_req", mem_req, 0);
      check("r mem_addr", mem_addr, 0);
      check("r mem_wdata", mem_wdata, 0);
      check("r mem_we", mem_we, 0);
      check("r dm_done", dm_done, 0);
      mem_ready = 1;
      step;
      mem_ready = 0;
      check("r stray done", dm_done, 0);
      check("r stray req", mem_req, 0);
      step;
      check("r stray done2", dm_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
